shift_monitor: RTL and testbench

SHIFT_MONITOR -- requirements
Module: shift_monitor

---
 rtl/shift_monitor.sv | 161 ++++++++++++++++
 tb/tb_shift_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_monitor.sv
// Purpose : tracks a one-hot bouncing shift pattern, reports position, direction,
//           reversal count and dwell, and latches the first protocol error.
// Latency : one cycle; every output is registered from the pattern of the previous posedge.
// Backpres: none; a pattern is sampled on every posedge, nothing can stall the monitor.
//
// Ports   : clk, reset (sync, active-high), pattern[7:0] (one-hot sample)
//           pos[2:0], dir, locked, err, err_code[1:0], rev_cnt[7:0], dwell[7:0]
// Config  : define SHIFT_MONITOR_DWELL_EN to build the dwell counter and the
//           "step before MIN_DWELL" check (err_code 11); otherwise dwell reads 0.
module shift_monitor #(
  parameter int unsigned MIN_DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pattern,
  output logic [2:0] pos,
  output logic       dir,
  output logic       locked,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] rev_cnt,
  output logic [7:0] dwell
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic       dir_q, dir_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [7:0] rev_q, rev_d;

  logic       is_onehot;
  logic [2:0] idx;
  logic       step_up, step_dn;
  logic       dwell_short;

  // Pattern decode: pattern & (pattern-1) clears the lowest set bit, so zero
  // means at most one bit was set.
  always_comb begin
    is_onehot = (pattern != 8'd0) && ((pattern & (pattern - 8'd1)) == 8'd0);
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pattern[i]) idx = 3'(i);
    end
    // Endpoint guards stop 3-bit arithmetic from wrapping 7<->0 into a "legal" step.
    step_up = (pos_q != 3'd7) && (idx == pos_q + 3'd1);
    step_dn = (pos_q != 3'd0) && (idx == pos_q - 3'd1);
  end

`ifdef SHIFT_MONITOR_DWELL_EN
  localparam logic [7:0] MIN_DWELL_B = MIN_DWELL[7:0];
  logic [7:0] dwell_q, dwell_d;
  assign dwell_short = (dwell_q < MIN_DWELL_B);
  assign dwell       = dwell_q;
`else
  logic [7:0] unused_min_dwell;
  assign unused_min_dwell = MIN_DWELL[7:0];
  assign dwell_short      = 1'b0;
  assign dwell            = 8'd0;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    err_d    = err_q;
    code_d   = code_q;
    rev_d    = rev_q;
`ifdef SHIFT_MONITOR_DWELL_EN
    dwell_d  = dwell_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_onehot) begin
          state_d  = TRACK;
          pos_d    = idx;
          dir_d    = 1'b1;
          locked_d = 1'b1;
`ifdef SHIFT_MONITOR_DWELL_EN
          dwell_d  = 8'd1;
`endif
        end
      end
      TRACK: begin
        // Checks are ordered so the highest-priority cause wins: 01 > 10 > 11.
        if (!is_onehot) begin
          state_d  = ERROR;
          err_d    = 1'b1;
          locked_d = 1'b0;
          code_d   = 2'b01;
        end else if (idx == pos_q) begin
`ifdef SHIFT_MONITOR_DWELL_EN
          if (dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
`endif
        end else if (!(step_up || step_dn)) begin
          state_d  = ERROR;
          err_d    = 1'b1;
          locked_d = 1'b0;
          code_d   = 2'b10;
        end else if (dwell_short) begin
          state_d  = ERROR;
          err_d    = 1'b1;
          locked_d = 1'b0;
          code_d   = 2'b11;
        end else begin
          pos_d = idx;
`ifdef SHIFT_MONITOR_DWELL_EN
          dwell_d = 8'd1;
`endif
          // A reversal is any legal step against the currently held direction.
          if (step_up != dir_q) begin
            dir_d = step_up;
            rev_d = rev_q + 8'd1;
          end
        end
      end
      ERROR: begin
        // Everything holds until reset.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pos_q    <= 3'd0;
      dir_q    <= 1'b1;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      rev_q    <= 8'd0;
`ifdef SHIFT_MONITOR_DWELL_EN
      dwell_q  <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      code_q   <= code_d;
      rev_q    <= rev_d;
`ifdef SHIFT_MONITOR_DWELL_EN
      dwell_q  <= dwell_d;
`endif
    end
  end

  assign pos      = pos_q;
  assign dir      = dir_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign rev_cnt  = rev_q;

endmodule

// File: tb/tb_shift_monitor.sv
// Purpose : self-checking bench for shift_monitor: directed scenarios followed by
//           a randomized bouncing walk, all checked against a rule-level model.
// Ports   : none (top-level bench).
module tb_shift_monitor;

  localparam int MIN_DW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pattern;
  logic [2:0] pos;
  logic       dir, locked, err;
  logic [1:0] err_code;
  logic [7:0] rev_cnt, dwell;

  shift_monitor #(.MIN_DWELL(MIN_DW)) dut (
    .clk(clk), .reset(reset), .pattern(pattern),
    .pos(pos), .dir(dir), .locked(locked), .err(err),
    .err_code(err_code), .rev_cnt(rev_cnt), .dwell(dwell)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = idle, 1 = tracking, 2 = error.
  int m_state, m_pos, m_dir, m_err, m_code, m_rev, m_dwell;

`ifdef SHIFT_MONITOR_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  task automatic model_step(input logic [7:0] p, input logic r);
    int idx, d;
    if (r) begin
      m_state = 0; m_pos = 0; m_dir = 1; m_err = 0; m_code = 0; m_rev = 0; m_dwell = 0;
    end else if (m_state == 0) begin
      if ($countones(p) == 1) begin
        m_state = 1; m_pos = $clog2(p); m_dir = 1; m_dwell = 1;
      end
    end else if (m_state == 1) begin
      if ($countones(p) != 1) begin
        m_state = 2; m_err = 1; m_code = 1;
      end else begin
        idx = $clog2(p);
        d = idx - m_pos;
        if (d == 0) begin
          m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
        end else if (d != 1 && d != -1) begin
          m_state = 2; m_err = 1; m_code = 2;
        end else if (DWELL_ON && m_dwell < MIN_DW) begin
          m_state = 2; m_err = 1; m_code = 3;
        end else begin
          if ((d == 1) != (m_dir == 1)) begin
            m_rev = (m_rev + 1) % 256;
            m_dir = (d == 1) ? 1 : 0;
          end
          m_pos = idx;
          m_dwell = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pos", {29'd0, pos}, m_pos);
    chk("dir", {31'd0, dir}, m_dir);
    chk("locked", {31'd0, locked}, (m_state == 1) ? 1 : 0);
    chk("err", {31'd0, err}, m_err);
    chk("err_code", {30'd0, err_code}, m_code);
    chk("rev_cnt", {24'd0, rev_cnt}, m_rev);
    chk("dwell", {24'd0, dwell}, DWELL_ON ? m_dwell : 0);
  endtask

  // Drive one sample, let the DUT take it on the posedge, then compare 1 ns later.
  task automatic apply(input logic [7:0] p, input logic r);
    pattern = p;
    reset   = r;
    @(posedge clk);
    model_step(p, r);
    n_vec++;
    #1;
    check_all();
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) apply(p, 1'b0);
  endtask

  int gpos, gdir, hleft, k;
  logic [7:0] cur;
  logic rr;

  initial begin
    pattern = 8'h00;
    reset   = 1'b1;
    m_state = 0; m_pos = 0; m_dir = 1; m_err = 0; m_code = 0; m_rev = 0; m_dwell = 0;

    // Reset state
    apply(8'h00, 1'b1);
    apply(8'h01, 1'b1);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_dir", {31'd0, dir}, 1);

    // Non-one-hot in idle is ignored
    apply(8'h00, 1'b0);
    apply(8'h05, 1'b0);
    chk("idle_ignore_err", {31'd0, err}, 0);

    // Lock at bit0, dwell 1..4
    for (int i = 1; i <= 4; i++) begin
      apply(8'h01, 1'b0);
      chk("lock_dwell", {24'd0, dwell}, DWELL_ON ? i : 0);
    end
    chk("lock_locked", {31'd0, locked}, 1);

    // Full sweep up then first step down
    for (int b = 1; b < 8; b++) hold(8'(1 << b), 4);
    chk("sweep_top", {29'd0, pos}, 7);
    hold(8'h40, 4);
    chk("sweep_dir", {31'd0, dir}, 0);
    chk("sweep_rev", {24'd0, rev_cnt}, 1);
    chk("sweep_err", {31'd0, err}, 0);

    // Non-one-hot while tracking at pos 2, then freeze
    apply(8'h00, 1'b1);
    hold(8'h01, 4); hold(8'h02, 4); hold(8'h04, 4);
    apply(8'h0C, 1'b0);
    chk("noh_code", {30'd0, err_code}, 2'b01);
    chk("noh_locked", {31'd0, locked}, 0);
    hold(8'h08, 4);
    hold(8'h04, 2);
    chk("noh_frozen_pos", {29'd0, pos}, 2);

    // Non-adjacent step at pos 2
    apply(8'h00, 1'b1);
    hold(8'h01, 4); hold(8'h02, 4); hold(8'h04, 4);
    apply(8'h10, 1'b0);
    chk("jump_code", {30'd0, err_code}, 2'b10);
    chk("jump_pos", {29'd0, pos}, 2);

    // No wrap at the endpoints
    apply(8'h00, 1'b1);
    hold(8'h80, 4);
    apply(8'h01, 1'b0);
    chk("wrap70_code", {30'd0, err_code}, 2'b10);
    apply(8'h00, 1'b1);
    hold(8'h01, 4);
    apply(8'h80, 1'b0);
    chk("wrap07_code", {30'd0, err_code}, 2'b10);

    // Early step after only 2 samples
    apply(8'h00, 1'b1);
    hold(8'h01, 2);
    apply(8'h02, 1'b0);
`ifdef SHIFT_MONITOR_DWELL_EN
    chk("early_code", {30'd0, err_code}, 2'b11);
`else
    chk("early_pos", {29'd0, pos}, 1);
    chk("early_err", {31'd0, err}, 0);
`endif

    // Reset mid-track at pos 5 with three reversals, then relock
    apply(8'h00, 1'b1);
    hold(8'h20, 4); hold(8'h10, 4); hold(8'h20, 4); hold(8'h40, 4); hold(8'h20, 4);
    chk("pre_rst_pos", {29'd0, pos}, 5);
    chk("pre_rst_rev", {24'd0, rev_cnt}, 3);
    apply(8'h20, 1'b1);
    chk("mid_rst_rev", {24'd0, rev_cnt}, 0);
    chk("mid_rst_pos", {29'd0, pos}, 0);
    apply(8'h20, 1'b0);
    chk("relock_pos", {29'd0, pos}, 5);
    chk("relock_dir", {31'd0, dir}, 1);

    // Randomized bouncing walk with occasional glitches, jumps and resets
    gpos = 0; gdir = 1; hleft = 0; cur = 8'h01;
    apply(8'h00, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if (hleft == 0) begin
        k = $urandom_range(0, 99);
        if (k < 82) begin
          if ($urandom_range(0, 4) == 0) gdir = -gdir;
          if (gpos + gdir < 0 || gpos + gdir > 7) gdir = -gdir;
          gpos = gpos + gdir;
          cur = 8'(1 << gpos);
          hleft = $urandom_range(1, 6);
        end else if (k < 91) begin
          cur = 8'($urandom_range(0, 255));
          hleft = 1;
        end else begin
          gpos = $urandom_range(0, 7);
          cur = 8'(1 << gpos);
          hleft = $urandom_range(1, 6);
        end
      end
      hleft--;
      rr = ($urandom_range(0, 99) < 2) || (m_state == 2 && $urandom_range(0, 7) == 0);
      apply(cur, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
